// File: rtl/game_pkg.sv
// Shared game-state encodings and default timing constants for the game control path.
package game_pkg;

    typedef enum logic [5:0] {
        ST_START  = 6'b000001,
        ST_GRA    = 6'b000010,
        ST_KONIEC = 6'b000100,
        ST_CZEKAJ = 6'b001000,
        ST_TRAF   = 6'b010000,
        ST_PUDLO  = 6'b100000
    } game_state_t;

    localparam int unsigned LIVES_DEF       = 3;
    localparam int unsigned HIT_FRAMES_DEF  = 30;
    localparam int unsigned MISS_FRAMES_DEF = 30;
    localparam int unsigned END_FRAMES_DEF  = 120;
    localparam int unsigned SCORE_W_DEF     = 8;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-cycle pulse on the rising edge of a level already synchronous to clk.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic in_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) in_q <= 1'b0;
        else      in_q <= in;
    end

    assign pulse = in & ~in_q;

endmodule

// File: rtl/game_fsm.sv
// Game control FSM: start/game/end screen selection, score and lives bookkeeping,
// and frame-timed hit/miss flash and end-screen lockout.
module game_fsm
    import game_pkg::*;
#(
    parameter int unsigned LIVES       = LIVES_DEF,
    parameter int unsigned HIT_FRAMES  = HIT_FRAMES_DEF,
    parameter int unsigned MISS_FRAMES = MISS_FRAMES_DEF,
    parameter int unsigned END_FRAMES  = END_FRAMES_DEF,
    parameter int unsigned SCORE_W     = SCORE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vsync,
    input  logic               left,
    input  logic               hit,
    input  logic               miss,
    output logic [5:0]         state_bin,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         lives
);

    localparam int unsigned MAX_FRAMES = max3(HIT_FRAMES, MISS_FRAMES, END_FRAMES);
    localparam int unsigned CNT_W      = $clog2(MAX_FRAMES + 1);

    localparam logic [CNT_W-1:0] HIT_LAST   = CNT_W'(HIT_FRAMES - 1);
    localparam logic [CNT_W-1:0] MISS_LAST  = CNT_W'(MISS_FRAMES - 1);
    localparam logic [CNT_W-1:0] END_CNT    = CNT_W'(END_FRAMES);
    localparam logic [2:0]       LIVES_INIT = 3'(LIVES);

    logic click;
    logic tick;

    game_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] score_d;
    logic [2:0]         lives_d;

    rise_detect u_left_edge (
        .clk   (clk),
        .rst   (rst),
        .in    (left),
        .pulse (click)
    );

    rise_detect u_vsync_edge (
        .clk   (clk),
        .rst   (rst),
        .in    (vsync),
        .pulse (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_START;
            cnt_q   <= '0;
            score   <= '0;
            lives   <= LIVES_INIT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            score   <= score_d;
            lives   <= lives_d;
        end
    end

    assign state_bin = state_q;

    // Next state, frame counter and score/lives updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        score_d = score;
        lives_d = lives;

        case (state_q)
            ST_START: begin
                if (click) state_d = ST_CZEKAJ;
            end
            ST_CZEKAJ: begin
                if (!left) begin
                    state_d = ST_GRA;
                    score_d = '0;
                    lives_d = LIVES_INIT;
                end
            end
            ST_GRA: begin
                if (hit) begin
                    state_d = ST_TRAF;
                    if (score != '1) score_d = score + SCORE_W'(1);
                end else if (miss) begin
                    if (lives > 3'd1) begin
                        state_d = ST_PUDLO;
                        lives_d = lives - 3'd1;
                    end else begin
                        state_d = ST_KONIEC;
                        lives_d = 3'd0;
                    end
                end
            end
            ST_TRAF: begin
                if (tick) begin
                    if (cnt_q == HIT_LAST) state_d = ST_GRA;
                    else                   cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_PUDLO: begin
                if (tick) begin
                    if (cnt_q == MISS_LAST) state_d = ST_GRA;
                    else                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_KONIEC: begin
                if (click && (cnt_q == END_CNT)) state_d = ST_START;
                else if (tick && (cnt_q != END_CNT)) cnt_d = cnt_q + CNT_W'(1);
            end
            default: begin
                state_d = ST_START;
            end
        endcase

        // Every phase starts its frame count from zero.
        if (state_d != state_q) cnt_d = '0;
    end

endmodule

// File: tb/tb_game_fsm.sv
// Directed bench for game_fsm with a countdown-style reference model checked every cycle.
module tb_game_fsm;

    localparam int unsigned SW     = 8;
    localparam int          NLIVES = 3;
    localparam int          NHIT   = 30;
    localparam int          NMISS  = 30;
    localparam int          NEND   = 120;

    localparam logic [5:0] B_START  = 6'b000001;
    localparam logic [5:0] B_GRA    = 6'b000010;
    localparam logic [5:0] B_KONIEC = 6'b000100;
    localparam logic [5:0] B_CZEKAJ = 6'b001000;
    localparam logic [5:0] B_TRAF   = 6'b010000;
    localparam logic [5:0] B_PUDLO  = 6'b100000;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          vsync = 1'b0;
    logic          left  = 1'b0;
    logic          hit   = 1'b0;
    logic          miss  = 1'b0;
    logic [5:0]    state_bin;
    logic [SW-1:0] score;
    logic [2:0]    lives;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    game_fsm #(
        .LIVES       (NLIVES),
        .HIT_FRAMES  (NHIT),
        .MISS_FRAMES (NMISS),
        .END_FRAMES  (NEND),
        .SCORE_W     (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vsync     (vsync),
        .left      (left),
        .hit       (hit),
        .miss      (miss),
        .state_bin (state_bin),
        .score     (score),
        .lives     (lives)
    );

    always #5 clk = ~clk;

    // Reference model: phase plus frames remaining, counted down.
    logic [5:0] m_bin;
    int         m_score;
    int         m_lives;
    int         m_wait;
    bit         m_left_p;
    bit         m_vs_p;
    bit         m_click;
    bit         m_tick;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_bin    = B_START;
            m_score  = 0;
            m_lives  = NLIVES;
            m_wait   = 0;
            m_left_p = 1'b0;
            m_vs_p   = 1'b0;
        end else begin
            m_click  = left && !m_left_p;
            m_tick   = vsync && !m_vs_p;
            m_left_p = left;
            m_vs_p   = vsync;
            if (m_bin == B_START) begin
                if (m_click) m_bin = B_CZEKAJ;
            end else if (m_bin == B_CZEKAJ) begin
                if (!left) begin
                    m_bin   = B_GRA;
                    m_score = 0;
                    m_lives = NLIVES;
                end
            end else if (m_bin == B_GRA) begin
                if (hit) begin
                    m_bin   = B_TRAF;
                    m_score = (m_score < 255) ? m_score + 1 : 255;
                    m_wait  = NHIT;
                end else if (miss) begin
                    m_lives = m_lives - 1;
                    if (m_lives == 0) begin
                        m_bin  = B_KONIEC;
                        m_wait = NEND;
                    end else begin
                        m_bin  = B_PUDLO;
                        m_wait = NMISS;
                    end
                end
            end else if (m_bin == B_TRAF || m_bin == B_PUDLO) begin
                if (m_tick) begin
                    m_wait = m_wait - 1;
                    if (m_wait == 0) m_bin = B_GRA;
                end
            end else if (m_bin == B_KONIEC) begin
                if (m_click && m_wait == 0) m_bin = B_START;
                else if (m_tick && m_wait > 0) m_wait = m_wait - 1;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_state", int'(state_bin), int'(m_bin));
            chk("model_score", int'(score), m_score);
            chk("model_lives", int'(lives), m_lives);
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic frame();
        vsync = 1'b1;
        nxt();
        vsync = 1'b0;
        nxt();
    endtask

    task automatic click();
        left = 1'b1;
        nxt();
        left = 1'b0;
        nxt();
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        nxt();
        hit = 1'b0;
    endtask

    task automatic pulse_miss();
        miss = 1'b1;
        nxt();
        miss = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) nxt();
        rst    = 1'b1;
        chk_en = 1'b1;
        chk("reset_state", int'(state_bin), int'(B_START));
        chk("reset_score", int'(score), 0);
        chk("reset_lives", int'(lives), 3);

        repeat (5) frame();
        chk("idle_state", int'(state_bin), int'(B_START));

        // Start click held for 10 cycles, then released.
        left = 1'b1;
        nxt();
        chk("czekaj_state", int'(state_bin), int'(B_CZEKAJ));
        repeat (9) nxt();
        chk("czekaj_hold", int'(state_bin), int'(B_CZEKAJ));
        left = 1'b0;
        nxt();
        chk("gra_state", int'(state_bin), int'(B_GRA));
        chk("gra_score", int'(score), 0);
        chk("gra_lives", int'(lives), 3);

        // Hit flash lasts exactly 30 ticks; a miss during it is dropped.
        pulse_hit();
        chk("traf_state", int'(state_bin), int'(B_TRAF));
        chk("traf_score", int'(score), 1);
        pulse_miss();
        repeat (29) frame();
        chk("traf_29", int'(state_bin), int'(B_TRAF));
        chk("traf_lives", int'(lives), 3);
        frame();
        chk("traf_30", int'(state_bin), int'(B_GRA));

        // Simultaneous hit and miss: hit wins.
        hit  = 1'b1;
        miss = 1'b1;
        nxt();
        hit  = 1'b0;
        miss = 1'b0;
        chk("both_state", int'(state_bin), int'(B_TRAF));
        chk("both_score", int'(score), 2);
        chk("both_lives", int'(lives), 3);
        repeat (30) frame();

        // Score saturation.
        repeat (253) begin
            pulse_hit();
            repeat (30) frame();
        end
        chk("score_255", int'(score), 255);
        pulse_hit();
        chk("sat_state", int'(state_bin), int'(B_TRAF));
        chk("sat_score", int'(score), 255);
        repeat (30) frame();

        // Three misses down to the end screen.
        pulse_miss();
        chk("miss1_state", int'(state_bin), int'(B_PUDLO));
        chk("miss1_lives", int'(lives), 2);
        repeat (30) frame();
        chk("pudlo_exit", int'(state_bin), int'(B_GRA));
        pulse_miss();
        chk("miss2_lives", int'(lives), 1);
        repeat (30) frame();
        pulse_miss();
        chk("miss3_state", int'(state_bin), int'(B_KONIEC));
        chk("miss3_lives", int'(lives), 0);

        // End-screen lockout.
        repeat (50) frame();
        click();
        chk("koniec_50", int'(state_bin), int'(B_KONIEC));
        repeat (69) frame();
        click();
        chk("koniec_119", int'(state_bin), int'(B_KONIEC));
        frame();
        click();
        chk("koniec_exit", int'(state_bin), int'(B_START));
        chk("held_score", int'(score), 255);
        chk("held_lives", int'(lives), 0);

        // New game, then asynchronous reset in the middle of a hit flash.
        click();
        chk("regame_state", int'(state_bin), int'(B_GRA));
        chk("regame_score", int'(score), 0);
        chk("regame_lives", int'(lives), 3);
        pulse_hit();
        repeat (5) frame();
        chk("pre_rst_state", int'(state_bin), int'(B_TRAF));
        rst = 1'b0;
        #1;
        chk("async_state", int'(state_bin), int'(B_START));
        chk("async_score", int'(score), 0);
        chk("async_lives", int'(lives), 3);
        nxt();
        rst = 1'b1;
        nxt();
        chk("post_rst_state", int'(state_bin), int'(B_START));

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
